dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//   Shares the single-port data memory between two requesters: port 0 (core load/store) and port 1
//   (debug/DMA loader). Round-robin arbitration, a lock mode for atomic read-modify-write sequences,
//   a lock timeout, and address range/alignment checking. Sits between the requesters and dmem.
//   dmem has combinational read and a clocked write; this block drives its A/WD/WE and registers RD.
// PARAMETERS
//   DMEM_BASE     32'h0010_0000  byte base address of the data memory window
//   DMEM_SIZE     32768          memory depth in 32-bit words; window = 4*DMEM_SIZE bytes
//   LOCK_TIMEOUT  64             max cycles a port may hold lock before forced release (>=2)
// PORTS
//   CLK           in   1   clock, all state updates on posedge
//   RST           in   1   reset, asynchronous, active-high
//   m0_req        in   1   port 0 access request (level; held until m0_gnt)
//   m0_we         in   1   port 0 write (1) / read (0)
//   m0_lock       in   1   port 0 requests exclusive ownership after this access
//   m0_addr       in   32  port 0 byte address
//   m0_wdata      in   32  port 0 write data
//   m0_gnt        out  1   port 0 access accepted this cycle (combinational)
//   m0_rvalid     out  1   port 0 response valid (one cycle after m0_gnt, one-cycle pulse)
//   m0_rdata      out  32  port 0 read data (0 for writes and errors)
//   m0_err        out  1   port 0 response error, qualified by m0_rvalid
//   m1_*          --   --  identical set for port 1 (req, we, lock, addr, wdata, gnt, rvalid, rdata, err)
//   mem_a         out  32  dmem byte address, offset from DMEM_BASE
//   mem_wd        out  32  dmem write data
//   mem_we        out  1   dmem write enable
//   mem_rd        in   32  dmem combinational read data
//   lock_timeout  out  1   one-cycle pulse when a lock is forcibly released
// BEHAVIOUR
//   Reset: state=ARB, last=1 (port 0 wins first tie), lock counter=0; all outputs 0.
//   Valid access: addr[1:0]==0 and DMEM_BASE <= addr < DMEM_BASE+4*DMEM_SIZE (compare in 33 bits, no wrap).
//   Granted cycle: mem_a = addr-DMEM_BASE, mem_wd = wdata, mem_we = we & valid. No grant: mem_* = 0.
//   Invalid access: granted normally, mem_we=0, response err=1, rdata=0.
//   Response: registered; at next posedge rvalid<=1, rdata<=(read & valid)?mem_rd:0, err<=~valid.
//   Throughput: one access per cycle total; gnt depends on req/state only, never on rvalid.
//   FSM states: ARB, LOCK0, LOCK1.
//   ARB: one req -> grant it; both -> grant port != last; last <= granted port.
//     Granted access with lock=1 -> LOCKn (n = granted port), counter <= 0.
//   LOCKn: only port n may be granted; other port stalls (gnt=0) regardless of req.
//     Granted access from n with lock=0 -> ARB after that access (access still performed).
//     req_n=0 and lock_n=0 -> ARB next cycle.
//     counter increments each cycle in LOCKn; counter==LOCK_TIMEOUT-1 -> ARB, lock_timeout=1
//     for one cycle; an access granted in that same cycle still completes normally.
//   Timeout takes priority over lock_n=1 on a granted access in the same cycle (goes to ARB).
//   After leaving LOCKn, last=n, so the other port wins the next tie.
//   RST mid-sequence: state, grants and pending rvalid cleared immediately; no response is delivered
//     for an access granted in the cycle RST asserts.
// TESTING
//   1 m0 write 0x0010_0008<=0xDEADBEEF, then read -> mem_a=0x8, mem_we=1; read rvalid next cycle, rdata=0xDEADBEEF, err=0.
//   2 m0,m1 req every cycle for 6 cycles after reset -> grants 0,1,0,1,0,1; each rvalid one cycle after its gnt.
//   3 m1 addr 0x0010_0002 write, then 0x0012_0000 read (DMEM_SIZE=32768) -> mem_we=0, err=1, rdata=0 for both.
//   4 m0 read lock=1, m1 req held high, m0 write lock=0 two cycles later -> m1_gnt=0 until m0 write granted, then m1 granted next cycle.
//   5 m0 lock=1 held 70 cycles, LOCK_TIMEOUT=64 -> lock_timeout pulse exactly 64 cycles after entry; m1 granted next cycle.
//   6 RST asserted in cycle after a grant -> rvalid, gnt, mem_we drop to 0 asynchronously; after release, first tie goes to port 0.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Requester and dmem-side signal bundle for dmem_arbiter.
// The arbiter uses the slave modport; requesters and memory sit on the master side.
interface dmem_arbiter_if;
  logic        m0_req, m0_we, m0_lock;
  logic [31:0] m0_addr, m0_wdata;
  logic        m0_gnt, m0_rvalid, m0_err;
  logic [31:0] m0_rdata;

  logic        m1_req, m1_we, m1_lock;
  logic [31:0] m1_addr, m1_wdata;
  logic        m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m1_rdata;

  logic [31:0] mem_a, mem_wd, mem_rd;
  logic        mem_we;
  logic        lock_timeout;

  modport slave (
    input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata, m0_err,
    input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata, m1_err,
    output mem_a, mem_wd, mem_we, lock_timeout,
    input  mem_rd
  );

  modport master (
    output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
    output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
    input  mem_a, mem_wd, mem_we, lock_timeout,
    output mem_rd
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of single-port dmem, with lock ownership,
// lock timeout and window/alignment checking. Responses are registered one cycle after grant.
module dmem_arbiter #(
  parameter logic [31:0] DMEM_BASE    = 32'h0010_0000,
  parameter int unsigned DMEM_SIZE    = 32768,
  parameter int unsigned LOCK_TIMEOUT = 64
) (
  input  logic           CLK,
  input  logic           RST,
  dmem_arbiter_if.slave  bus
);

  localparam int unsigned   CW      = $clog2(LOCK_TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_TIMEOUT - 1);
  // 33-bit window bounds so a window ending at 4 GiB cannot wrap
  localparam logic [32:0]   WIN_LO  = {1'b0, DMEM_BASE};
  localparam logic [32:0]   WIN_HI  = WIN_LO + (33'(DMEM_SIZE) << 2);

  typedef struct packed {
    logic        req;
    logic        we;
    logic        lock;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_t;

  req_t   [1:0] rq;
  rsp_t   [1:0] rsp;
  logic   [1:0] valid, gnt;
  logic         gsel, own, timeout;
  logic         last, last_n;
  state_t       state, state_n;
  logic [CW-1:0] cnt, cnt_n;

  assign rq[0] = {bus.m0_req, bus.m0_we, bus.m0_lock, bus.m0_addr, bus.m0_wdata};
  assign rq[1] = {bus.m1_req, bus.m1_we, bus.m1_lock, bus.m1_addr, bus.m1_wdata};

  for (genvar i = 0; i < 2; i++) begin : g_chk
    logic [32:0] a33;
    assign a33      = {1'b0, rq[i].addr};
    assign valid[i] = (rq[i].addr[1:0] == 2'b00) && (a33 >= WIN_LO) && (a33 < WIN_HI);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ARB;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_n;
      last  <= last_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    gnt     = '0;
    state_n = state;
    last_n  = last;
    cnt_n   = cnt;
    timeout = 1'b0;
    own     = (state == LOCK1);
    unique case (state)
      ARB: begin
        if (rq[0].req && (!rq[1].req || last)) gnt = 2'b01;
        else if (rq[1].req)                    gnt = 2'b10;
        if (|gnt) begin
          last_n = gnt[1];
          if (rq[gnt[1]].lock) begin
            state_n = gnt[1] ? LOCK1 : LOCK0;
            cnt_n   = '0;
          end
        end
      end
      LOCK0, LOCK1: begin
        gnt[own] = rq[own].req;
        last_n   = own;
        cnt_n    = cnt + 1'b1;
        // timeout wins even if the owner is re-asserting lock this cycle
        if (cnt == CNT_MAX) begin
          timeout = 1'b1;
          state_n = ARB;
        end else if (!rq[own].lock) begin
          state_n = ARB;
        end
      end
      default: state_n = ARB;
    endcase
    if (RST) gnt = '0;
  end

  assign gsel             = gnt[1];
  assign bus.m0_gnt       = gnt[0];
  assign bus.m1_gnt       = gnt[1];
  assign bus.mem_a        = (|gnt) ? (rq[gsel].addr - DMEM_BASE) : '0;
  assign bus.mem_wd       = (|gnt) ? rq[gsel].wdata : '0;
  assign bus.mem_we       = (|gnt) & rq[gsel].we & valid[gsel];
  assign bus.lock_timeout = timeout;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rsp <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        rsp[i].rvalid <= gnt[i];
        rsp[i].rdata  <= (gnt[i] && !rq[i].we && valid[i]) ? bus.mem_rd : '0;
        rsp[i].err    <= gnt[i] && !valid[i];
      end
    end
  end

  assign bus.m0_rvalid = rsp[0].rvalid;
  assign bus.m0_rdata  = rsp[0].rdata;
  assign bus.m0_err    = rsp[0].err;
  assign bus.m1_rvalid = rsp[1].rvalid;
  assign bus.m1_rdata  = rsp[1].rdata;
  assign bus.m1_err    = rsp[1].err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: stimulus pushes expected responses, a monitor pops on rvalid.
module tb_dmem_arbiter;
  localparam logic [31:0] BASE = 32'h0010_0000;

  typedef struct { logic [31:0] rdata; logic err; } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  dmem_arbiter_if bus();
  dmem_arbiter dut (.CLK(CLK), .RST(RST), .bus(bus));

  logic [1:0]  req, we, lk;
  logic [31:0] ad [2];
  logic [31:0] wd [2];
  logic [1:0]  gnt;

  assign bus.m0_req = req[0];  assign bus.m0_we = we[0];  assign bus.m0_lock = lk[0];
  assign bus.m0_addr = ad[0];  assign bus.m0_wdata = wd[0];
  assign bus.m1_req = req[1];  assign bus.m1_we = we[1];  assign bus.m1_lock = lk[1];
  assign bus.m1_addr = ad[1];  assign bus.m1_wdata = wd[1];
  assign gnt = {bus.m1_gnt, bus.m0_gnt};

  // memory model: combinational read, clocked write, filled with a known pattern on first edge
  logic [31:0] mem [0:32767];
  logic mem_ready = 1'b0;
  assign bus.mem_rd = mem[bus.mem_a[16:2]];
  always @(posedge CLK) begin
    if (!mem_ready) begin
      for (int i = 0; i < 32768; i++) mem[i] <= 32'hA5A5_0000 + i;
      mem_ready <= 1'b1;
    end else if (bus.mem_we) begin
      mem[bus.mem_a[16:2]] <= bus.mem_wd;
    end
  end

  int   checks = 0, failures = 0;
  exp_t q0[$];
  exp_t q1[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic push(input int p, input logic [31:0] rd, input logic e);
    exp_t x;
    x.rdata = rd;
    x.err   = e;
    if (p == 0) q0.push_back(x);
    else        q1.push_back(x);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin : mon
    exp_t r;
    if (bus.m0_rvalid) begin
      checks++;
      if (q0.size() == 0) begin
        failures++;
        $display("FAIL m0_unexpected_rvalid actual=1 required=0");
      end else begin
        r = q0.pop_front();
        checks--;
        chk("m0_rdata", bus.m0_rdata, r.rdata);
        chk("m0_err", {31'b0, bus.m0_err}, {31'b0, r.err});
      end
    end
    if (bus.m1_rvalid) begin
      checks++;
      if (q1.size() == 0) begin
        failures++;
        $display("FAIL m1_unexpected_rvalid actual=1 required=0");
      end else begin
        r = q1.pop_front();
        checks--;
        chk("m1_rdata", bus.m1_rdata, r.rdata);
        chk("m1_err", {31'b0, bus.m1_err}, {31'b0, r.err});
      end
    end
  end

  // single access on port p, held until granted (bounded)
  task automatic issue(input int p, input logic w, input logic l, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err);
    bit got = 0;
    req[p] = 1'b1; we[p] = w; lk[p] = l; ad[p] = a; wd[p] = d;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge CLK);
      if (gnt[p]) got = 1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL gnt_timeout port=%0d actual=0 required=1", p);
    end else begin
      chk("mem_a", bus.mem_a, a - BASE);
      chk("mem_we", {31'b0, bus.mem_we}, {31'b0, w & ~exp_err});
      if (w & ~exp_err) chk("mem_wd", bus.mem_wd, d);
      push(p, exp_rd, exp_err);
    end
    @(posedge CLK);
    #1;
    req[p] = 1'b0; lk[p] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req = 2'b11; we = 2'b00; lk = 2'b00;
    ad[0] = BASE; ad[1] = BASE; wd[0] = '0; wd[1] = '0;

    // reset state with both requests asserted
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_gnt", {30'b0, gnt}, 0);
    chk("rst_rvalid", {30'b0, bus.m1_rvalid, bus.m0_rvalid}, 0);
    chk("rst_mem_we", {31'b0, bus.mem_we}, 0);
    chk("rst_mem_a", bus.mem_a, 0);
    chk("rst_lock_timeout", {31'b0, bus.lock_timeout}, 0);
    req = 2'b00;
    RST = 1'b0;
    tick();

    // alternating grants under continuous contention, port 0 first
    req = 2'b11; ad[0] = BASE; ad[1] = BASE + 4;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      chk("rr_gnt", {30'b0, gnt}, (i % 2 == 0) ? 32'd1 : 32'd2);
      if (i % 2 == 0) push(0, 32'hA5A5_0000, 1'b0);
      else            push(1, 32'hA5A5_0001, 1'b0);
      tick();
    end
    req = 2'b00;
    tick();

    // write then read back
    issue(0, 1, 0, BASE + 8, 32'hDEAD_BEEF, 32'h0, 0);
    issue(0, 0, 0, BASE + 8, 32'h0, 32'hDEAD_BEEF, 0);

    // range and alignment boundaries
    issue(1, 1, 0, BASE + 2,       32'h55, 32'h0, 1);
    issue(1, 0, 0, 32'h0012_0000,  32'h0,  32'h0, 1);
    issue(1, 0, 0, BASE - 4,       32'h0,  32'h0, 1);
    issue(1, 0, 0, BASE + 5,       32'h0,  32'h0, 1);
    issue(1, 0, 0, 32'hFFFF_FFFC,  32'h0,  32'h0, 1);
    issue(1, 1, 0, 32'h0011_FFFC,  32'h1234_5678, 32'h0, 0);
    issue(1, 0, 0, 32'h0011_FFFC,  32'h0, 32'h1234_5678, 0);

    // lock by port 0 stalls port 1 until an unlocked access
    req[0] = 1; we[0] = 0; lk[0] = 1; ad[0] = BASE;
    @(negedge CLK);
    chk("lk_enter_gnt", {30'b0, gnt}, 1);
    push(0, 32'hA5A5_0000, 0);
    tick();
    req[0] = 0; req[1] = 1; we[1] = 0; lk[1] = 0; ad[1] = BASE + 4;
    @(negedge CLK);
    chk("lk_hold_gnt", {30'b0, gnt}, 0);
    tick();
    req[0] = 1; we[0] = 1; lk[0] = 0; ad[0] = BASE + 16; wd[0] = 32'hCAFE_F00D;
    @(negedge CLK);
    chk("lk_release_gnt", {30'b0, gnt}, 1);
    push(0, 32'h0, 0);
    tick();
    req[0] = 0; we[0] = 0;
    @(negedge CLK);
    chk("lk_after_gnt", {30'b0, gnt}, 2);
    push(1, 32'hA5A5_0001, 0);
    tick();
    req[1] = 0;
    issue(1, 0, 0, BASE + 16, 32'h0, 32'hCAFE_F00D, 0);

    // lock timeout: pulse 64 cycles after entry, then port 1 gets in
    req = 2'b11; we = 2'b00; lk = 2'b01; ad[0] = BASE; ad[1] = BASE + 4;
    @(negedge CLK);
    chk("to_enter_gnt", {30'b0, gnt}, 1);
    chk("to_enter_pulse", {31'b0, bus.lock_timeout}, 0);
    push(0, 32'hA5A5_0000, 0);
    tick();
    req[0] = 0;
    for (int k = 1; k <= 70; k++) begin
      @(negedge CLK);
      chk("to_pulse", {31'b0, bus.lock_timeout}, (k == 64) ? 32'd1 : 32'd0);
      chk("to_gnt", {30'b0, gnt}, (k >= 65) ? 32'd2 : 32'd0);
      if (k >= 65) push(1, 32'hA5A5_0001, 0);
      tick();
    end
    req = 2'b00; lk = 2'b00;
    tick();

    // reset in the cycle after a grant kills the pending response and the new write
    req[0] = 1; we[0] = 0; ad[0] = BASE;
    @(negedge CLK);
    chk("rs_first_gnt", {30'b0, gnt}, 1);
    @(posedge CLK);
    #1;
    we[0] = 1; ad[0] = BASE + 32; wd[0] = 32'hBAD0_BAD0;
    #1;
    chk("rs_pre_rvalid", {31'b0, bus.m0_rvalid}, 1);
    chk("rs_pre_mem_we", {31'b0, bus.mem_we}, 1);
    RST = 1'b1;
    #1;
    chk("rs_rvalid", {31'b0, bus.m0_rvalid}, 0);
    chk("rs_gnt", {30'b0, gnt}, 0);
    chk("rs_mem_we", {31'b0, bus.mem_we}, 0);
    req = 2'b00; we = 2'b00;
    repeat (2) @(posedge CLK);
    #2;
    RST = 1'b0;
    tick();
    req = 2'b11; ad[0] = BASE + 32; ad[1] = BASE + 4;
    @(negedge CLK);
    chk("rs_tie_gnt", {30'b0, gnt}, 1);
    push(0, 32'hA5A5_0008, 0);
    tick();
    @(negedge CLK);
    chk("rs_tie2_gnt", {30'b0, gnt}, 2);
    push(1, 32'hA5A5_0001, 0);
    tick();
    req = 2'b00;
    repeat (3) tick();

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
